// File: rtl/spec_0_if.sv
// Lane sequence bus: arm/fire inputs and the two response flags.
interface spec_0_if;
  logic a_1_0;
  logic a_1_1;
  logic c_1_0;
  logic c_1_1;

  modport master (
    output a_1_0,
    output a_1_1,
    input  c_1_0,
    input  c_1_1
  );

  modport slave (
    input  a_1_0,
    input  a_1_1,
    output c_1_0,
    output c_1_1
  );
endinterface

// File: rtl/spec_0.sv
// Two-input sequence responder: a_1_0 then a_1_1 one cycle later raises both flags.
// Optional output hold-stretch is compiled in with SPEC0_STRETCH_EN.
//
// state     | meaning
// ST_IDLE   | a_1_0 was low (or reset) last cycle; a fire cannot hit
// ST_ARMED  | a_1_0 was high last cycle; a_1_1 this cycle is a hit
module spec_0 #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic     clock,
  input  logic     reset_n,
  spec_0_if.slave  bus
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..255");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   armed_q;
  logic   hit;
  logic   hold_active;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (bus.a_1_0) begin
      state_d = ST_ARMED;
    end
  end

  assign armed_q = (state_q == ST_ARMED);
  assign hit     = armed_q & bus.a_1_1 & reset_n;

`ifdef SPEC0_STRETCH_EN
  logic [7:0] stretch_q;

  // A retrigger reloads rather than accumulates.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stretch_q <= 8'd0;
    end else if (hit) begin
      stretch_q <= HOLD_CYCLES[7:0];
    end else if (stretch_q != 8'd0) begin
      stretch_q <= stretch_q - 8'd1;
    end
  end

  assign hold_active = (stretch_q != 8'd0);
`else
  assign hold_active = 1'b0;
`endif

  // Gated by reset_n so the flags read 0 throughout a reset cycle.
  assign bus.c_1_0 = reset_n & (armed_q | hold_active);
  assign bus.c_1_1 = reset_n & (hit | hold_active);

endmodule

// File: tb/tb_spec_0.sv
// Directed and randomized bench for spec_0; expectations follow SPEC0_STRETCH_EN.
module tb_spec_0;
  localparam int HOLD = 2;
`ifdef SPEC0_STRETCH_EN
  localparam bit STR = 1'b1;
`else
  localparam bit STR = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  spec_0_if bus ();

  spec_0 #(.HOLD_CYCLES(HOLD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle: drive after the rising edge, compare at the falling edge.
  task automatic cyc(input logic r, input logic a0, input logic a1,
                     input logic e0, input logic e1, input string tag);
    @(posedge clock);
    #1;
    reset_n   = r;
    bus.a_1_0 = a0;
    bus.a_1_1 = a1;
    @(negedge clock);
    chk({tag, ".c_1_0"}, bus.c_1_0, e0);
    chk({tag, ".c_1_1"}, bus.c_1_1, e1);
  endtask

  initial begin
    logic       m_armed;
    logic [7:0] m_str;
    logic       p_a0;
    logic       p_r;
    logic       r;
    logic       a0;
    logic       a1;
    logic       e0;
    logic       e1;
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    bus.a_1_0 = 1'b0;
    bus.a_1_1 = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "release");

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "basic_arm");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "basic_hit");
    cyc(1'b1, 1'b0, 1'b0, STR, STR, "basic_n2");
    cyc(1'b1, 1'b0, 1'b0, STR, STR, "basic_n3");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "basic_n4");

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "order_fire");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "order_arm");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "order_n2");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "order_n3");

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_n0");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "b2b_n1");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "b2b_n2");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "b2b_n3");
    cyc(1'b1, 1'b0, 1'b0, STR, STR, "b2b_n4");
    cyc(1'b1, 1'b0, 1'b0, STR, STR, "b2b_n5");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_n6");

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_arm");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst_fire");

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_arm");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "mid_hit");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_rst");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid_after1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid_after2");

    // Randomized run against a reference model; state is known idle here.
    m_armed = 1'b0;
    m_str   = 8'd0;
    p_a0    = 1'b0;
    p_r     = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(15) != 0);
      a0 = $urandom_range(1);
      a1 = $urandom_range(1);
      e0 = r & (m_armed | (STR & (m_str != 8'd0)));
      e1 = r & ((m_armed & a1) | (STR & (m_str != 8'd0)));
      cyc(r, a0, a1, e0, e1, "rand");
      if (r && p_r && p_a0 && a1) begin
        chk("seq_prop.c_1_0", bus.c_1_0, 1'b1);
        chk("seq_prop.c_1_1", bus.c_1_1, 1'b1);
      end
      if (!r) m_str = 8'd0;
      else if (m_armed && a1) m_str = HOLD[7:0];
      else if (m_str != 8'd0) m_str = m_str - 8'd1;
      m_armed = r & a0;
      p_a0    = a0;
      p_r     = r;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
